// File: rtl/arb_id_return_router.sv
`default_nettype none
// ============================================================================
// arb_id_return_router: registers arbitrated requests for one slave, tracks
// issued indices in an in-order ID FIFO and routes responses back one-hot.
// Optional macro: ARB_ID_ROUTER_ERR_CNT_EN (saturating dropped-response count)
// Revision: 1.0
// ============================================================================
module arb_id_return_router #(
  parameter int NumIn          = 8,
  parameter int DataWidth      = 32,
  parameter int RspWidth       = 32,
  parameter int MaxOutstanding = 4,
  parameter int IdxWidth       = $clog2(NumIn)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 arb_req_i,
  output logic                 arb_gnt_o,
  input  logic [DataWidth-1:0] arb_data_i,
  input  logic [IdxWidth-1:0]  arb_idx_i,
  output logic                 slv_req_o,
  input  logic                 slv_gnt_i,
  output logic [DataWidth-1:0] slv_data_o,
  input  logic                 slv_rsp_valid_i,
  input  logic [RspWidth-1:0]  slv_rsp_data_i,
  output logic [NumIn-1:0]     rsp_valid_o,
  output logic [RspWidth-1:0]  rsp_data_o,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic                 reg_valid_q, reg_valid_d;
  logic [DataWidth-1:0] reg_data_q;
  logic [IdxWidth-1:0]  reg_idx_q;
  logic [IdxWidth-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NumIn-1:0]     rsp_valid_q, rsp_valid_d;
  logic [RspWidth-1:0]  rsp_data_q;
  logic                 err_q;

  logic fifo_full, fifo_empty, push, pop, orphan, load;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CntFull);
  assign fifo_empty = (cnt_q == '0);
  assign slv_req_o  = reg_valid_q & ~fifo_full;
  assign push       = slv_req_o & slv_gnt_i;
  assign arb_gnt_o  = ~reg_valid_q | push;
  assign load       = arb_req_i & arb_gnt_o;
  // A response arriving while empty is an orphan even if a push lands this cycle.
  assign pop        = slv_rsp_valid_i & ~fifo_empty;
  assign orphan     = slv_rsp_valid_i & fifo_empty;

  always_comb begin
    reg_valid_d = reg_valid_q;
    if (load)      reg_valid_d = 1'b1;
    else if (push) reg_valid_d = 1'b0;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d       = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rsp_valid_d = pop ? (NumIn'(1) << fifo_q[rd_ptr_q]) : '0;
    if (flush_i) begin
      reg_valid_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_valid_q <= 1'b0;
      reg_data_q  <= '0;
      reg_idx_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      reg_valid_q <= reg_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      if (load && !flush_i) begin
        reg_data_q <= arb_data_i;
        reg_idx_q  <= arb_idx_i;
      end
      if (pop && !flush_i) rsp_data_q <= slv_rsp_data_i;
      if (orphan)          err_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) fifo_q[wr_ptr_q] <= reg_idx_q;
  end

`ifdef ARB_ID_ROUTER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           err_cnt_q <= 8'd0;
    else if (orphan && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

  assign slv_data_o  = reg_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_id_return_router.sv
`default_nettype none
// Scoreboard bench for arb_id_return_router: directed vectors, queue-based
// slave-request and response monitors plus point checks on control outputs.
module tb_arb_id_return_router;

`ifdef ARB_ID_ROUTER_ERR_CNT_EN
  localparam logic [7:0] EXP_CNT1 = 8'd1, EXP_CNT2 = 8'd2, EXP_CNT_SAT = 8'd255;
`else
  localparam logic [7:0] EXP_CNT1 = 8'd0, EXP_CNT2 = 8'd0, EXP_CNT_SAT = 8'd0;
`endif

  logic        clk = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic        arb_req_i = 1'b0, arb_gnt_o;
  logic [31:0] arb_data_i = '0;
  logic [2:0]  arb_idx_i = '0;
  logic        slv_req_o, slv_gnt_i = 1'b0;
  logic [31:0] slv_data_o;
  logic        slv_rsp_valid_i = 1'b0;
  logic [31:0] slv_rsp_data_i = '0;
  logic [7:0]  rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int checks = 0, failures = 0;
  logic [31:0] exp_req[$];
  logic [39:0] exp_rsp[$];

  arb_id_return_router dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .arb_req_i(arb_req_i), .arb_gnt_o(arb_gnt_o), .arb_data_i(arb_data_i), .arb_idx_i(arb_idx_i),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_data_o(slv_data_o),
    .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_data_i(slv_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] idx, input logic [31:0] d);
    arb_req_i = 1'b1; arb_idx_i = idx; arb_data_i = d;
    exp_req.push_back(d);
  endtask

  task automatic respond(input logic [7:0] oh, input logic [31:0] d);
    slv_rsp_valid_i = 1'b1; slv_rsp_data_i = d;
    if (oh != 8'h00) exp_rsp.push_back({oh, d});
  endtask

  task automatic idle();
    arb_req_i = 1'b0; slv_rsp_valid_i = 1'b0;
  endtask

  // Slave-side monitor: every request handshake must carry the next expected payload.
  always @(negedge clk) begin
    if (!rst_i && slv_req_o && slv_gnt_i) begin
      if (exp_req.size() == 0) chk("unexpected_slv_handshake", {32'h0, slv_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("slv_data", {32'h0, slv_data_o}, {32'h0, exp_req.pop_front()});
    end
  end

  // Response monitor: any non-zero one-hot must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o != 8'h00) begin
      if (exp_rsp.size() == 0) chk("unexpected_rsp", {24'h0, rsp_valid_o, rsp_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rsp", {24'h0, rsp_valid_o, rsp_data_o}, {24'h0, exp_rsp.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    mid();
    chk("rst_arb_gnt", arb_gnt_o, 1);
    chk("rst_slv_req", slv_req_o, 0);
    chk("rst_slv_data", slv_data_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);

    // Back-to-back throughput
    slv_gnt_i = 1'b1;
    cyc(); issue(3, 32'hA3); mid(); chk("b2b_gnt", arb_gnt_o, 1); chk("b2b_req0", slv_req_o, 0);
    cyc(); issue(5, 32'hA5); mid(); chk("b2b_req1", slv_req_o, 1);
    cyc(); issue(1, 32'hA1); mid(); chk("b2b_req2", slv_req_o, 1);
    cyc(); idle();           mid(); chk("b2b_req3", slv_req_o, 1);
    cyc();                   mid(); chk("b2b_req_done", slv_req_o, 0);
    cyc(); respond(8'h08, 32'h1000_0000);
    cyc(); respond(8'h20, 32'h1000_0001);
    cyc(); respond(8'h02, 32'h1000_0002);
    cyc(); idle();
    cyc();

    // FIFO full
    for (int k = 0; k < 5; k++) begin
      cyc(); issue(3'(k), 32'(32'hB0 + k));
    end
    cyc(); idle(); mid(); chk("full_req", slv_req_o, 0); chk("full_gnt", arb_gnt_o, 0);
    cyc(); respond(8'h01, 32'hC0); mid(); chk("full_pop_cycle_req", slv_req_o, 0);
    cyc(); idle(); mid(); chk("req_after_pop", slv_req_o, 1);
    cyc(); mid(); chk("full_again_req", slv_req_o, 0);
    cyc(); respond(8'h02, 32'hC1);
    cyc(); respond(8'h04, 32'hC2);
    cyc(); respond(8'h08, 32'hC3);
    cyc(); respond(8'h10, 32'hC4);
    cyc(); idle();
    cyc(); mid(); chk("no_err_yet", err_o, 0);

    // Slave backpressure
    cyc(); slv_gnt_i = 1'b0; issue(4, 32'hD4); mid(); chk("bp_first_gnt", arb_gnt_o, 1);
    cyc(); arb_req_i = 1'b1; arb_idx_i = 3'd5; arb_data_i = 32'hD5;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_req", slv_req_o, 1);
      chk("bp_data", slv_data_o, 32'hD4);
      chk("bp_gnt", arb_gnt_o, 0);
      cyc();
    end
    slv_gnt_i = 1'b1; exp_req.push_back(32'hD5); mid(); chk("bp_release_gnt", arb_gnt_o, 1);
    cyc(); idle();
    cyc();
    cyc(); respond(8'h10, 32'hE4);
    cyc(); respond(8'h20, 32'hE5);
    cyc(); idle();
    cyc();

    // Flush with 3 outstanding and a held register entry
    cyc(); issue(1, 32'hF1);
    cyc(); issue(2, 32'hF2);
    cyc(); issue(3, 32'hF3);
    cyc(); arb_req_i = 1'b1; arb_idx_i = 3'd0; arb_data_i = 32'hF0;
    cyc(); idle(); slv_gnt_i = 1'b0; flush_i = 1'b1;
    cyc(); flush_i = 1'b0; slv_gnt_i = 1'b1; respond(8'h00, 32'hDEAD);
    mid(); chk("flush_req", slv_req_o, 0); chk("flush_gnt", arb_gnt_o, 1);
    cyc(); idle(); mid();
    chk("flush_orphan_err", err_o, 1);
    chk("flush_orphan_cnt", err_cnt_o, EXP_CNT1);
    chk("flush_orphan_rsp", rsp_valid_o, 0);

    // Simultaneous push/pop at count 2
    cyc(); issue(6, 32'h66);
    cyc(); issue(7, 32'h77);
    cyc(); idle();
    cyc(); issue(2, 32'h22);
    cyc(); idle(); respond(8'h40, 32'hAA0); mid(); chk("pp_push", slv_req_o, 1);
    cyc(); respond(8'h80, 32'hAA1);
    cyc(); respond(8'h04, 32'hAA2);
    cyc(); respond(8'h00, 32'hBAD);
    cyc(); idle(); mid(); chk("pp_orphan_cnt", err_cnt_o, EXP_CNT2);

    // Saturation: 300 orphans in total
    cyc(); respond(8'h00, 32'hBAD);
    repeat (298) cyc();
    idle();
    cyc(); mid();
    chk("sat_cnt", err_cnt_o, EXP_CNT_SAT);
    chk("sat_err", err_o, 1);

    chk("exp_req_drained", exp_req.size(), 0);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
